dpram_port_arbiter: RTL
=======================

// Module: dpram_port_arbiter
// PURPOSE
//  Shares port A of one dpram between NUM_REQ requesters with round-robin arbitration.
//  Optional locked bursts hold the port for one requester, capped at MAX_BURST accesses.
//  Sits between the core's client logic (CPU, blitter, video fetch) and the dpram instance.
//  Fixed read latency of 2 cycles from grant to rd_valid.
// PARAMETERS
//  NUM_REQ        4   number of requesters, 1..8
//  address_width  10  dpram address width
//  data_width     8   dpram data width
//  MAX_BURST      16  max consecutive locked grants to one requester, >=1
// PORTS
//  clk        in   1                      system clock; also drives dpram clock_a
//  reset_n    in   1                      synchronous active-low reset
//  req_valid  in   NUM_REQ                per-requester access request
//  req_we     in   NUM_REQ                1=write, 0=read; held with req_valid
//  req_lock   in   NUM_REQ                request burst ownership of the port
//  req_addr   in   NUM_REQ*address_width  flattened addresses; requester i at [i*aw +: aw]
//  req_data   in   NUM_REQ*data_width     flattened write data; requester i at [i*dw +: dw]
//  req_ready  out  NUM_REQ                one-hot grant pulse; the access is accepted this cycle
//  rd_valid   out  NUM_REQ                one-hot read-data strobe
//  rd_data    out  data_width             read data, shared; qualified by rd_valid
//  ram_wren   out  1                      to dpram wren_a
//  ram_addr   out  address_width          to dpram address_a
//  ram_wdata  out  data_width             to dpram data_a
//  ram_q      in   data_width             from dpram q_a
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): req_ready=0, rd_valid=0, rd_data=0, ram_wren=0, ram_addr=0, ram_wdata=0.
//    Also: state=ARB, last_grant=NUM_REQ-1 so requester 0 wins first, burst_cnt=0, pipeline tags cleared.
//  - Handshake: a requester holds valid/we/lock/addr/data stable until it sees req_ready.
//    It may change them, or drop valid, on the cycle after req_ready.
//  - req_ready is combinational from state, the request vectors and last_grant. At most one bit is set per cycle.
//  - ARB state: grant the first i with req_valid[i], searching from last_grant+1 upward with wrap modulo NUM_REQ.
//    No valid request means no grant and ram_wren=0.
//  - Grant cycle N: last_grant<=i. ram_wren/ram_addr/ram_wdata are registered from requester i and valid in N+1.
//    For a read, the tag {valid,i} moves through 2 pipeline stages. rd_valid[i]=1 and rd_data=ram_q in cycle N+2.
//  - Writes never raise rd_valid. rd_data holds its last value when rd_valid=0.
//  - Back-to-back: a new grant is allowed every cycle, so throughput is 1 access/cycle.
//  - Idle cycles drive ram_wren=0. ram_addr/ram_wdata hold their previous values.
//  - FSM ARB -> LOCKED: a grant to i with req_lock[i]=1 sets owner=i and burst_cnt=1.
//  - LOCKED: only the owner can be granted. A grant happens when req_valid[owner]=1, and each grant increments burst_cnt.
//  - LOCKED -> ARB: when req_lock[owner]=0 on a granted access, or req_valid[owner]=0.
//    Also when burst_cnt==MAX_BURST after a grant; that grant is the final one of the burst.
//  - When LOCKED exits because req_valid[owner]=0, no grant happens that cycle and the port goes to ARB next cycle.
//  - On exit, last_grant=owner, so the other requesters get priority. burst_cnt is cleared.
//  - If the owner is the only requester after exit, it is granted again (work-conserving).
//  - MAX_BURST=1: locking has no effect, and every grant returns to ARB.
//  - NUM_REQ=1: the grant goes to 0 whenever req_valid[0]=1. The pointer logic reduces to a constant.
//  - Reset mid-operation: in-flight read tags are dropped, and no rd_valid appears after reset for pre-reset grants.
//  - Widths: burst_cnt is $clog2(MAX_BURST+1) bits. The pointer is $clog2(NUM_REQ) bits, minimum 1.
// STRUCTURE
//  - Package dpram_arb_pkg: state enum {ARB, LOCKED}.
//    Also holds the helper functions for flattened-bus slicing and pointer wrap.
//  - Sub-module rr_priority_pick: combinational round-robin picker.
//    Inputs: request vector and last pointer. Outputs: one-hot grant and index.
//  - Top level holds the FSM, burst counter, RAM-side registers and 2-stage read-tag pipeline.
//    It connects one port of an unmodified dpram.
// TESTING
//  - Reset, then req0 reads addr 0x010 holding 0xA5 -> req_ready[0] at cycle N, ram_addr=0x010 at N+1,
//    rd_valid[0]=1 and rd_data=0xA5 at N+2.
//  - req0..3 all valid (reads) continuously -> grants in order 0,1,2,3,0,1 on consecutive cycles.
//    Each rd_valid arrives 2 cycles after its grant.
//  - req1 writes 0x3C to 0x020, then req2 reads 0x020 on the next grant -> rd_valid[2] with rd_data=0x3C.
//    rd_valid[1] never asserts.
//  - MAX_BURST=4, req_lock[2]=1 with req0 and req3 also valid -> exactly 4 grants to req2 in a row.
//    The next grant goes to req3, then req0.
//  - Two reads in flight, reset_n=0 for 1 cycle -> all outputs 0 and no rd_valid afterwards.
//    Next grant after reset goes to the lowest valid index.
//  - req1 locked, drops req_lock on its 3rd access -> 3 grants to req1, then ARB resumes at req2.

Source files
------------

// File: rtl/dpram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpram_arb_pkg
// Purpose  : Shared types and helpers for the dpram port-A arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dpram_arb_pkg;

  // Arbiter operating modes: free round-robin or held by a locked burst owner
  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Round-robin pointer advance with wrap, e.g. ptr_wrap(last, k, n)
  function automatic int ptr_wrap(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

  // Low bit of element idx in a flattened bus of w-bit elements
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dpram_port_arbiter_if
// Purpose  : Requester-side and RAM-side signals of the dpram port arbiter.
//            master = environment (requesters + dpram), slave = arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dpram_port_arbiter_if
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int address_width = 10,
  parameter int data_width    = 8
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_we;
  logic [NUM_REQ-1:0]               req_lock;
  logic [NUM_REQ*address_width-1:0] req_addr;
  logic [NUM_REQ*data_width-1:0]    req_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rd_valid;
  logic [data_width-1:0]            rd_data;
  logic                             ram_wren;
  logic [address_width-1:0]         ram_addr;
  logic [data_width-1:0]            ram_wdata;
  logic [data_width-1:0]            ram_q;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_data, ram_q,
    input  req_ready, rd_valid, rd_data, ram_wren, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_data, ram_q,
    output req_ready, rd_valid, rd_data, ram_wren, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/dpram_port_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational round-robin picker. Searches upward from last_i+1
//            with wrap and returns the first requester as one-hot and index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  logic [PTR_W-1:0] cand_p;

  // First requester after the last grant wins; the last grant itself is tried last
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_p = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_p = PTR_W'(ptr_wrap(int'(last_i), k, NUM_REQ));
      if (!any_o && req_i[cand_p]) begin
        any_o         = 1'b1;
        gnt_o[cand_p] = 1'b1;
        idx_o         = cand_p;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpram_port_arbiter
// Purpose  : Shares port A of a dpram between NUM_REQ requesters with
//            round-robin arbitration and optional capped locked bursts.
//            Grant in cycle N -> RAM strobes in N+1 -> read data in N+2.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int address_width = 10,
  parameter int data_width    = 8,
  parameter int MAX_BURST     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dpram_port_arbiter_if.slave   bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [0:0]       ST_ARB    = ARB;
  localparam logic [0:0]       ST_LOCKED = LOCKED;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]         state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;

  logic [NUM_REQ-1:0] rr_gnt, gnt;
  logic [PTR_W-1:0]   rr_idx, gnt_idx;
  logic               rr_any, gnt_any;

  logic                     ram_wren_q;
  logic [address_width-1:0] ram_addr_q;
  logic [data_width-1:0]    ram_wdata_q;
  logic                     tag1_v_q, tag2_v_q;
  logic [PTR_W-1:0]         tag1_i_q, tag2_i_q;
  logic [data_width-1:0]    rd_hold_q;

  logic [address_width-1:0] addr_arr [NUM_REQ];
  logic [data_width-1:0]    data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = bus.req_addr[slice_lo(gi, address_width) +: address_width];
    assign data_arr[gi] = bus.req_data[slice_lo(gi, data_width) +: data_width];
  end

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

  assign cnt_inc = cnt_q + CNT_ONE;

  // Grant selection and ARB/LOCKED transitions; no grant while reset is held
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = rr_idx;
    if (reset_n) begin
      if (state_q == ST_ARB) begin
        if (rr_any) begin
          gnt     = rr_gnt;
          gnt_any = 1'b1;
          last_d  = rr_idx;
          // A one-access burst cap makes locking meaningless, so stay in ARB
          if (bus.req_lock[rr_idx] && (MAX_BURST > 1)) begin
            state_d = ST_LOCKED;
            owner_d = rr_idx;
            cnt_d   = CNT_ONE;
          end
        end
      end else begin
        if (bus.req_valid[owner_q]) begin
          gnt[owner_q] = 1'b1;
          gnt_any      = 1'b1;
          gnt_idx      = owner_q;
          last_d       = owner_q;
          cnt_d        = cnt_inc;
          if (!bus.req_lock[owner_q] || (cnt_inc == CNT_MAX)) begin
            state_d = ST_ARB;
            cnt_d   = '0;
          end
        end else begin
          // Owner went idle: release without granting; others get priority next
          state_d = ST_ARB;
          cnt_d   = '0;
          last_d  = owner_q;
        end
      end
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_ARB;
      owner_q <= '0;
      last_q  <= PTR_LAST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM-side strobes; address/data hold across idle cycles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_wren_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_wren_q <= gnt_any & bus.req_we[gnt_idx];
      if (gnt_any) begin
        ram_addr_q  <= addr_arr[gnt_idx];
        ram_wdata_q <= data_arr[gnt_idx];
      end
    end
  end

  // Two-stage read tag matching the dpram's registered read latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag1_v_q  <= 1'b0;
      tag1_i_q  <= '0;
      tag2_v_q  <= 1'b0;
      tag2_i_q  <= '0;
      rd_hold_q <= '0;
    end else begin
      tag1_v_q <= gnt_any & ~bus.req_we[gnt_idx];
      tag1_i_q <= gnt_idx;
      tag2_v_q <= tag1_v_q;
      tag2_i_q <= tag1_i_q;
      if (tag2_v_q) begin
        rd_hold_q <= bus.ram_q;
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rd_valid  = tag2_v_q ? (NUM_REQ'(1) << tag2_i_q) : '0;
  assign bus.rd_data   = tag2_v_q ? bus.ram_q : rd_hold_q;
  assign bus.ram_wren  = ram_wren_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire
